spi_reg_sequencer: RTL

- Upstream command stage for the SPI byte engine. Accepts one register-access command: R/W flag, 15-bit address, 8-bit write data.
- Splits the command into a 3-byte frame, issues each byte to the byte engine over its trigger/busy/data-valid handshake, and returns a response.
- For reads, the response carries the byte clocked in during the third frame byte.
- Sits between the host control logic (register map / test controller) and the SPI byte engine.

---
 rtl/spi_reg_sequencer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/spi_reg_sequencer.sv
// SPI register-access sequencer.
// Takes one host command (rw, address, write data), sends it to the SPI byte
// engine as a 3-byte frame using the engine's trigger/busy/data-valid
// handshake, and returns a single-cycle response. For reads, the response
// carries the byte received during the third frame byte.
module spi_reg_sequencer #(
    parameter int unsigned ADDR_WIDTH     = 15,
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    // host command channel
    input  logic                  cmd_valid_in,
    output logic                  cmd_ready_out,
    input  logic                  cmd_rw_in,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_in,
    input  logic [7:0]            cmd_wdata_in,
    // host response channel
    output logic                  rsp_valid_out,
    output logic [7:0]            rsp_rdata_out,
    output logic                  rsp_err_out,
    // byte engine handshake
    output logic [7:0]            spi_data_out,
    output logic                  spi_trigger_out,
    input  logic                  spi_busy_in,
    input  logic                  spi_data_valid_in,
    input  logic [7:0]            spi_data_in
);

    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWaitBusy,
        StWaitDone,
        StGap,
        StResp,
        StErr
    } state_e;

    state_e          state_q;
    logic            rw_q;
    logic [14:0]     addr_q;
    logic [7:0]      wdata_q;
    logic [1:0]      byte_idx_q;
    logic [GapW-1:0] gap_cnt_q;
    logic [TmoW-1:0] tmo_cnt_q;
    logic            cmd_ready_q;
    logic            rsp_valid_q;
    logic [7:0]      rsp_rdata_q;
    logic            rsp_err_q;
    logic [7:0]      spi_data_q;
    logic            spi_trigger_q;

    // Frame layout: {rw, addr[14:8]}, addr[7:0], then write data (zero for reads).
    function automatic logic [7:0] frame_byte(input logic [1:0]  idx,
                                              input logic        rw,
                                              input logic [14:0] addr,
                                              input logic [7:0]  wdata);
        logic [7:0] b;
        case (idx)
            2'd0:    b = {rw, addr[14:8]};
            2'd1:    b = addr[7:0];
            2'd2:    b = rw ? 8'h00 : wdata;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    logic [14:0] cmd_addr15;
    logic [1:0]  next_idx;
    logic [7:0]  first_byte;
    logic [7:0]  next_byte;
    logic        last_byte;

    // Byte selection for the first byte (from the live command) and later bytes (latched).
    always_comb begin
        cmd_addr15 = 15'(cmd_addr_in);
        next_idx   = byte_idx_q + 2'd1;
        first_byte = frame_byte(2'd0, cmd_rw_in, cmd_addr15, cmd_wdata_in);
        next_byte  = frame_byte(next_idx, rw_q, addr_q, wdata_q);
        last_byte  = (byte_idx_q == 2'd2);
    end

    // Sequencer FSM; every output is registered and set on entry to the state that owns it.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q       <= StIdle;
            rw_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            byte_idx_q    <= '0;
            gap_cnt_q     <= '0;
            tmo_cnt_q     <= '0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            spi_data_q    <= '0;
            spi_trigger_q <= 1'b0;
        end else begin
            // pulse outputs default low
            spi_trigger_q <= 1'b0;
            rsp_valid_q   <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (cmd_valid_in && cmd_ready_q) begin
                        rw_q          <= cmd_rw_in;
                        addr_q        <= cmd_addr15;
                        wdata_q       <= cmd_wdata_in;
                        byte_idx_q    <= 2'd0;
                        spi_data_q    <= first_byte;
                        spi_trigger_q <= 1'b1;
                        cmd_ready_q   <= 1'b0;
                        state_q       <= StLoad;
                    end else begin
                        // first IDLE cycle after reset release raises ready here
                        cmd_ready_q <= 1'b1;
                    end
                end

                StLoad: begin
                    tmo_cnt_q <= '0;
                    state_q   <= StWaitBusy;
                end

                StWaitBusy: begin
                    if (spi_busy_in) begin
                        tmo_cnt_q <= '0;
                        state_q   <= StWaitDone;
                    end else if (tmo_cnt_q == TmoLast) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= 8'h00;
                        state_q     <= StErr;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
                    end
                end

                StWaitDone: begin
                    // completion wins over a coincident terminal count
                    if (spi_data_valid_in) begin
                        if (last_byte) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            rsp_rdata_q <= rw_q ? spi_data_in : 8'h00;
                            state_q     <= StResp;
                        end else begin
                            gap_cnt_q <= '0;
                            state_q   <= StGap;
                        end
                    end else if (tmo_cnt_q == TmoLast) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= 8'h00;
                        state_q     <= StErr;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
                    end
                end

                StGap: begin
                    if (gap_cnt_q == GapLast) begin
                        byte_idx_q    <= next_idx;
                        spi_data_q    <= next_byte;
                        spi_trigger_q <= 1'b1;
                        state_q       <= StLoad;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GapW'(1);
                    end
                end

                StResp, StErr: begin
                    cmd_ready_q <= 1'b1;
                    state_q     <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign cmd_ready_out   = cmd_ready_q;
    assign rsp_valid_out   = rsp_valid_q;
    assign rsp_rdata_out   = rsp_rdata_q;
    assign rsp_err_out     = rsp_err_q;
    assign spi_data_out    = spi_data_q;
    assign spi_trigger_out = spi_trigger_q;

endmodule
